// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial unsigned subtractor, LSB first, one bit per clock
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             busy,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] r_sh;
    logic             br;
    logic [CW-1:0]    cnt;

    logic ai;
    logic bi;
    logic d;
    logic br_next;

    // Full-subtractor cell applied to the current operand LSBs and the carried borrow
    always_comb begin
        ai      = a_sh[0];
        bi      = b_sh[0];
        d       = ai ^ bi ^ br;
        br_next = (~ai & bi) | (~ai & br) | (bi & br);
    end

    // Control FSM and datapath; outputs are registered and only diff/borrow survive an operation
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            r_sh   <= '0;
            br     <= 1'b0;
            cnt    <= '0;
            diff   <= '0;
            borrow <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        br    <= 1'b0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    r_sh <= {d, r_sh[WIDTH-1:1]};
                    br   <= br_next;
                    cnt  <= cnt + CW'(1);
                    if (cnt == LAST_BIT) begin
                        // the last difference bit lands in the MSB of the published result
                        diff   <= {d, r_sh[WIDTH-1:1]};
                        borrow <= br_next;
                        busy   <= 1'b0;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - randomized self-checking bench for serial_subtractor
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] diff;
    logic         borrow;
    logic         busy;
    logic         done;

    int n_tests = 0;
    int n_fail  = 0;

    // last completed result as predicted by the model (what diff/borrow must hold)
    int exp_diff   = 0;
    int exp_borrow = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .diff   (diff),
        .borrow (borrow),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Caller is at a negedge. Launches one subtraction, checks busy/done timing,
    // result stability during the run and the final result against plain arithmetic.
    task automatic do_op(input int ta, input int tb_v, input bit scramble, input bit hold_start);
        int busy_cnt;
        int done_at;
        int done_cnt;
        int unstable;
        int want_d;
        int want_b;
        want_d = (ta - tb_v) & ((1 << W) - 1);
        want_b = (ta < tb_v) ? 1 : 0;
        a     = W'(ta);
        b     = W'(tb_v);
        start = 1'b1;
        busy_cnt = 0;
        done_at  = -1;
        done_cnt = 0;
        unstable = 0;
        for (int k = 0; k <= W + 1; k++) begin
            @(negedge clk);
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) begin
                done_cnt++;
                done_at = k;
            end
            if (k < W && (int'(diff) != exp_diff || int'(borrow) != exp_borrow)) unstable++;
            if (!hold_start) start = 1'b0;
            if (scramble) begin
                a = W'($urandom);
                b = W'($urandom);
            end
        end
        exp_diff   = want_d;
        exp_borrow = want_b;
        check("busy_cycles", busy_cnt, W);
        check("done_cycle", done_at, W + 1);
        check("done_pulses", done_cnt, 1);
        check("stable_in_run", unstable, 0);
        check("diff", int'(diff), want_d);
        check("borrow", int'(borrow), want_b);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clk);
        check("rst_diff", int'(diff), 0);
        check("rst_borrow", int'(borrow), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        rst = 1'b0;

        // directed operand cases
        do_op(200, 55, 1'b0, 1'b0);
        do_op(5, 10, 1'b0, 1'b0);
        do_op(0, 0, 1'b0, 1'b0);
        do_op(255, 255, 1'b0, 1'b0);
        do_op(0, 1, 1'b0, 1'b0);

        // start held high: restarts only every W+2 cycles
        for (int i = 0; i < 4; i++) do_op(9, 4, 1'b0, 1'b1);
        start = 1'b0;
        @(negedge clk);

        // operand inputs churn throughout the run
        do_op(100, 30, 1'b1, 1'b0);

        // reset during the 4th RUN cycle aborts the operation
        begin
            int late_done;
            a     = W'(50);
            b     = W'(20);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            repeat (3) @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            exp_diff   = 0;
            exp_borrow = 0;
            check("abort_busy", int'(busy), 0);
            check("abort_done", int'(done), 0);
            check("abort_diff", int'(diff), 0);
            check("abort_borrow", int'(borrow), 0);
            late_done = 0;
            repeat (W + 4) begin
                @(negedge clk);
                if (done === 1'b1 || busy === 1'b1) late_done++;
            end
            check("abort_no_done", late_done, 0);
        end
        do_op(7, 3, 1'b0, 1'b0);

        // randomized operands against the arithmetic model
        for (int i = 0; i < 1000; i++) begin
            do_op(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), i[0], 1'b0);
        end

        start = 1'b0;
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
